// File: rtl/tone_sample_gen.sv
// Square-wave PCM sample generator with a linear attack/release envelope.
// Turns the sequencer's tone half-period into a continuous codec sample stream.
module tone_sample_gen #(
  parameter int unsigned             SAMPLE_WIDTH = 32,
  parameter int unsigned             DELAY_WIDTH  = 19,
  parameter logic [SAMPLE_WIDTH-1:0] AMPLITUDE    = 32'd10000000,
  parameter int unsigned             RAMP_STEPS   = 16
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    play,
  input  logic [DELAY_WIDTH-1:0]  delay,
  input  logic                    audio_out_allowed,
  output logic                    write_audio_out,
  output logic [SAMPLE_WIDTH-1:0] left_channel_audio_out,
  output logic [SAMPLE_WIDTH-1:0] right_channel_audio_out,
  output logic                    note_active
);

  localparam int unsigned LEVEL_WIDTH = $clog2(RAMP_STEPS) + 1;

  localparam logic [LEVEL_WIDTH-1:0]  LEVEL_ZERO  = {LEVEL_WIDTH{1'b0}};
  localparam logic [LEVEL_WIDTH-1:0]  LEVEL_ONE   = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0]  LEVEL_FULL  = LEVEL_WIDTH'(RAMP_STEPS);
  localparam logic [DELAY_WIDTH-1:0]  DELAY_ZERO  = {DELAY_WIDTH{1'b0}};
  localparam logic [DELAY_WIDTH-1:0]  DELAY_ONE   = DELAY_WIDTH'(1);
  localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_ZERO = {SAMPLE_WIDTH{1'b0}};
  localparam logic [SAMPLE_WIDTH-1:0] STEP        =
    SAMPLE_WIDTH'(AMPLITUDE / SAMPLE_WIDTH'(RAMP_STEPS));

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DELAY_WIDTH-1:0]  active_delay_q, active_delay_d;
  logic [DELAY_WIDTH-1:0]  phase_cnt_q, phase_cnt_d;
  logic                    sq_q, sq_d;
  logic [LEVEL_WIDTH-1:0]  level_q, level_d;
  logic                    running_q;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;

  logic                    accept_s;
  logic                    start_s;
  logic                    note_change_s;
  logic                    phase_wrap_s;
  logic [LEVEL_WIDTH-1:0]  level_inc_s;
  logic [LEVEL_WIDTH-1:0]  level_dec_s;
  logic [SAMPLE_WIDTH-1:0] amp_s;

  assign accept_s      = running_q & audio_out_allowed;
  assign start_s       = play && (delay != DELAY_ZERO);
  assign note_change_s = !play || (delay != active_delay_q);
  assign phase_wrap_s  = (phase_cnt_q == (active_delay_q - DELAY_ONE));
  assign level_inc_s   = (level_q == LEVEL_FULL) ? LEVEL_FULL : (level_q + LEVEL_ONE);
  assign level_dec_s   = (level_q == LEVEL_ZERO) ? LEVEL_ZERO : (level_q - LEVEL_ONE);
  assign amp_s         = STEP * SAMPLE_WIDTH'(level_q);

  // Envelope FSM: next state, level and latched tone period
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    active_delay_d = active_delay_q;
    case (state_q)
      ST_IDLE: begin
        level_d = LEVEL_ZERO;
        if (start_s) begin
          state_d        = ST_ATTACK;
          active_delay_d = delay;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (accept_s) begin
          level_d = level_inc_s;
        end else begin
          level_d = level_q;
        end
        // An abort outranks reaching full level on the same sample
        if (note_change_s) begin
          state_d = ST_RELEASE;
        end else if (accept_s && (level_inc_s == LEVEL_FULL)) begin
          state_d = ST_SUSTAIN;
        end else begin
          state_d = ST_ATTACK;
        end
      end
      ST_SUSTAIN: begin
        level_d = LEVEL_FULL;
        if (note_change_s) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_SUSTAIN;
        end
      end
      ST_RELEASE: begin
        if (accept_s) begin
          level_d = level_dec_s;
        end else begin
          level_d = level_q;
        end
        if (accept_s && (level_dec_s == LEVEL_ZERO)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = LEVEL_ZERO;
      end
    endcase
  end

  // Half-period counter and square-wave polarity, independent of the FIFO handshake
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    sq_d        = sq_q;
    if (state_q == ST_IDLE) begin
      phase_cnt_d = DELAY_ZERO;
      sq_d        = 1'b1;
    end else if (phase_wrap_s) begin
      phase_cnt_d = DELAY_ZERO;
      sq_d        = ~sq_q;
    end else begin
      phase_cnt_d = phase_cnt_q + DELAY_ONE;
      sq_d        = sq_q;
    end
  end

  // Next sample word: signed envelope amplitude, silent while idle
  always_comb begin
    sample_d = SAMPLE_ZERO;
    if (state_q == ST_IDLE) begin
      sample_d = SAMPLE_ZERO;
    end else if (sq_q) begin
      sample_d = amp_s;
    end else begin
      sample_d = -amp_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      active_delay_q <= DELAY_ZERO;
      phase_cnt_q    <= DELAY_ZERO;
      sq_q           <= 1'b0;
      level_q        <= LEVEL_ZERO;
      running_q      <= 1'b0;
      sample_q       <= SAMPLE_ZERO;
    end else begin
      state_q        <= state_d;
      active_delay_q <= active_delay_d;
      phase_cnt_q    <= phase_cnt_d;
      sq_q           <= sq_d;
      level_q        <= level_d;
      running_q      <= 1'b1;
      sample_q       <= sample_d;
    end
  end

  assign write_audio_out         = running_q & audio_out_allowed;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign note_active             = (state_q != ST_IDLE);

endmodule

// File: doc/tone_sample_gen.md
# tone_sample_gen

Converts the tone half-period (`delay`) produced by the song sequencer into a stream of signed square-wave PCM samples for the audio codec's output FIFO. It sits between the note sequencer/`Song_FSM` output and the codec write port. It applies a linear attack/release envelope on every note start, note change and stop, so transitions are click-free. Left and right channels carry identical samples.

## Interface
- `SAMPLE_WIDTH`, 32: sample word width, two's complement.
- `DELAY_WIDTH`, 19: width of `delay`.
- `AMPLITUDE`, 32'd10000000: peak magnitude at full level. Must be < 2^(SAMPLE_WIDTH-1).
- `RAMP_STEPS`, 16: envelope steps from 0 to full. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: clock.
- `Reset`  in  1: reset, asynchronous, active-high.
- `play`  in  1: sound enable from player control.
- `delay`  in  DELAY_WIDTH: tone half-period in clk cycles; 0 = rest.
- `audio_out_allowed`  in  1: codec FIFO has space.
- `write_audio_out`  out  1: sample write strobe.
- `left_channel_audio_out`  out  SAMPLE_WIDTH: current sample.
- `right_channel_audio_out`  out  SAMPLE_WIDTH: identical to left.
- `note_active`  out  1: high in ATTACK/SUSTAIN/RELEASE.

## Operation
- Registers:
  - `state`
  - `active_delay` (DELAY_WIDTH)
  - `phase_cnt` (DELAY_WIDTH)
  - `sq` (1)
  - `level` (log2(RAMP_STEPS)+1 bits, range 0..RAMP_STEPS)
  - `running` (1)
- Accepted sample: any cycle with `write_audio_out && audio_out_allowed`. Envelope advances only on accepted samples.
- `STEP = AMPLITUDE / RAMP_STEPS`, computed at elaboration. `amp = STEP * level`, SAMPLE_WIDTH wide.
- Sample register: `sq ? amp : -amp` (two's complement). Forced to 0 in IDLE.
- Phase:
  - Outside IDLE, `phase_cnt` increments every clk.
  - When `phase_cnt == active_delay-1`: `phase_cnt` ← 0 and `sq` toggles.
  - Phase runs independently of the FIFO handshake.
- FSM states and transitions:
  - IDLE:
    - `level` = 0.
    - If `play && delay != 0`: `active_delay` ← `delay`, `phase_cnt` ← 0, `sq` ← 1, go to ATTACK.
  - ATTACK:
    - `level`+1 per accepted sample.
    - Go to SUSTAIN on the accepted sample that makes `level == RAMP_STEPS`.
    - Abort to RELEASE on `!play || delay != active_delay`; release starts from the current level.
  - SUSTAIN:
    - `level` held at RAMP_STEPS.
    - `!play || delay != active_delay` → RELEASE.
  - RELEASE:
    - `level`−1 per accepted sample.
    - Go to IDLE on the accepted sample that makes `level == 0`.
    - Always completes: `delay` returning to `active_delay`, or `play` reasserting, does not cancel it.
    - `active_delay` is frozen, so the old tone fades out.
- New notes: IDLE reloads the new `delay` the cycle after RELEASE ends. A note change therefore produces release → IDLE (1 cycle) → attack.
- Rests: `delay == 0` releases the current note, then stays in IDLE, writing zero samples.
- Arithmetic: `level` saturates at 0 and RAMP_STEPS. `amp` never exceeds AMPLITUDE.
- Write strobe: `write_audio_out = running && audio_out_allowed` (combinational). Zeros are written in IDLE so the codec stream stays continuous.
- `running` ← 1 on the first clk edge after `Reset` deasserts.
- `Reset` mid-operation:
  - State → IDLE.
  - `level`, `phase_cnt`, `active_delay`, `sq`, `running` and samples → 0.
  - `write_audio_out` → 0 immediately, asynchronously.

## Timing
- Reset values: `write_audio_out` 0, both channel outputs 0, `note_active` 0.
- Input change at edge N is seen at edge N+1 and acted on there (state/`level` updated). Sample output reflects the new `level`/`sq` from edge N+2.
- Phase: with constant `delay = D`, `sq` toggles every D clk cycles. Full period is 2D cycles.
- Attack: IDLE→SUSTAIN takes 1 cycle plus RAMP_STEPS accepted samples. Release is symmetric.
- Stalls: while `audio_out_allowed` is low, `level` and state are held (except abort transitions). Samples keep updating with `sq`.
- Simultaneous ramp end and abort in ATTACK: the abort wins; go to RELEASE with `level` at its incremented value.

## Test plan
Bench settings: RAMP_STEPS=4, AMPLITUDE=400 (STEP=100), `audio_out_allowed` held 1 unless stated.

1. Assert `Reset`, then release with `play=0` → all outputs 0 during reset. `write_audio_out` = 1 from the first edge after release; samples stay 0; `note_active` = 0.
2. `play=1`, `delay=4` → ATTACK. Sample magnitudes 100, 200, 300, 400, then SUSTAIN. Sign flips every 4 cycles (+ first). `note_active` = 1.
3. In SUSTAIN, change `delay` 4→6 → 4 release samples (300, 200, 100, 0) at the 4-cycle phase, 1 IDLE cycle, then attack at 6-cycle toggling.
4. In SUSTAIN, hold `audio_out_allowed=0` for 10 cycles, then drop `play` → no writes; state enters RELEASE but `level` stays 4 until `audio_out_allowed` returns, then ramps down and IDLE is reached.
5. `play=1`, `delay=0` → stays IDLE, zero samples written continuously, `note_active` = 0. Then `delay=5` → attack starts on the next edge.
6. Assert `Reset` mid-ATTACK (`level`=2) → same cycle: `write_audio_out` 0, samples 0. After release: IDLE, then attack from `level` 0.
